// File: rtl/add_pipe.sv
// Two-stage valid/ready adder/subtractor with 8086-style flags: S1 adds the low half, S2 the high half.
// Optional flag datapath (of, zf, sf, af, pf) is built only when ADD_PIPE_FLAGS_EN is defined.
module add_pipe #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cf,
    output logic             of,
    output logic             zf,
    output logic             sf,
    output logic             af,
    output logic             pf
);
    localparam int H = WIDTH / 2;

    logic [2:1] vld_pipe;
    logic       s2_free, s1_adv, in_take;

    assign s2_free   = !vld_pipe[2] | out_ready;
    assign s1_adv    = vld_pipe[1] & s2_free;
    assign in_ready  = flush | !vld_pipe[1] | s2_free;
    assign in_take   = in_valid & in_ready;
    assign out_valid = vld_pipe[2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
        end else if (flush) begin
            vld_pipe <= '0;
        end else begin
            if (s2_free)  vld_pipe[2] <= vld_pipe[1];
            if (in_ready) vld_pipe[1] <= in_valid;
        end
    end

    // Subtract is a + ~b + ~cin, so both modes share one adder.
    logic [WIDTH-1:0] bx;
    logic             c0;
    logic [H:0]       lo;

    assign bx = sub ? ~b : b;
    assign c0 = sub ^ cin;
    assign lo = {1'b0, a[H-1:0]} + {1'b0, bx[H-1:0]} + (H+1)'(c0);

    logic [H-1:0] s1_lo, s1_ahi, s1_bhi;
    logic         s1_c, s1_sub;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_lo  <= '0;
            s1_ahi <= '0;
            s1_bhi <= '0;
            s1_c   <= 1'b0;
            s1_sub <= 1'b0;
        end else if (in_take) begin
            s1_lo  <= lo[H-1:0];
            s1_ahi <= a[WIDTH-1:H];
            s1_bhi <= bx[WIDTH-1:H];
            s1_c   <= lo[H];
            s1_sub <= sub;
        end
    end

    logic [H:0]       hi;
    logic [WIDTH-1:0] res;

    assign hi  = {1'b0, s1_ahi} + {1'b0, s1_bhi} + (H+1)'(s1_c);
    assign res = {hi[H-1:0], s1_lo};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum <= '0;
            cf  <= 1'b0;
        end else if (s1_adv) begin
            sum <= res;
            cf  <= hi[H] ^ s1_sub;
        end
    end

`ifdef ADD_PIPE_FLAGS_EN
    // Bit 3 always lives in the low half (H >= 4), so af is resolved in S1.
    logic [4:0]   nib;
    logic         s1_af;
    logic [H-1:0] hi_msb;

    assign nib    = {1'b0, a[3:0]} + {1'b0, bx[3:0]} + 5'(c0);
    assign hi_msb = {1'b0, s1_ahi[H-2:0]} + {1'b0, s1_bhi[H-2:0]} + H'(s1_c);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)          s1_af <= 1'b0;
        else if (in_take) s1_af <= nib[4] ^ sub;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            of <= 1'b0;
            zf <= 1'b0;
            sf <= 1'b0;
            af <= 1'b0;
            pf <= 1'b0;
        end else if (s1_adv) begin
            of <= hi_msb[H-1] ^ hi[H];
            zf <= (res == '0);
            sf <= res[WIDTH-1];
            af <= s1_af;
            pf <= ~^res[7:0];
        end
    end
`else
    assign of = 1'b0;
    assign zf = 1'b0;
    assign sf = 1'b0;
    assign af = 1'b0;
    assign pf = 1'b0;
`endif

endmodule

// File: tb/tb_add_pipe.sv
// Randomized + directed bench for add_pipe (WIDTH=16) against an arithmetic reference model.
module tb_add_pipe;
    localparam int W = 16;

`ifdef ADD_PIPE_FLAGS_EN
    localparam logic [5:0] FMASK = 6'b111111;
`else
    localparam logic [5:0] FMASK = 6'b100000;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0, in_ready;
    logic [W-1:0] a = '0, b = '0;
    logic         cin = 1'b0, sub = 1'b0, flush = 1'b0;
    logic         out_valid, out_ready = 1'b1;
    logic [W-1:0] sum;
    logic         cf, of, zf, sf, af, pf;

    int n_tests = 0;
    int n_fail  = 0;

    add_pipe #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
        .cf(cf), .of(of), .zf(zf), .sf(sf), .af(af), .pf(pf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // {sum, cf, of, zf, sf, af, pf} from plain integer arithmetic
    function automatic logic [W+5:0] ref_model(input logic [W-1:0] x, input logic [W-1:0] y,
                                               input logic ci, input logic sb);
        longint       xa = longint'(x), ya = longint'(y), r;
        logic [W-1:0] s;
        logic         c, o, h;
        if (!sb) begin
            r = xa + ya + longint'(ci);
            c = (r > 64'hFFFF);
            h = ((xa & 15) + (ya & 15) + longint'(ci)) > 15;
        end else begin
            r = xa - ya - longint'(ci);
            c = (r < 0);
            h = (xa & 15) < ((ya & 15) + longint'(ci));
        end
        s = W'(r & 64'hFFFF);
        if (!sb) o = (x[W-1] == y[W-1]) && (s[W-1] != x[W-1]);
        else     o = (x[W-1] != y[W-1]) && (s[W-1] != x[W-1]);
        return {s, c, o, (s == '0), s[W-1], h, ~^s[7:0]};
    endfunction

    function automatic logic [5:0] dut_flags();
        return {cf, of, zf, sf, af, pf};
    endfunction

    logic [W+5:0] q[$];
    logic         hold_p = 1'b0;
    logic [W-1:0] hold_sum = '0;

    // Scoreboard: expected results follow accepted inputs in order
    always @(negedge clk) begin
        logic [W+5:0] e;
        if (!rst) begin
            if (hold_p && out_valid) chk("hold_sum", 32'(sum), 32'(hold_sum));
            hold_p   <= out_valid & !out_ready & !flush;
            hold_sum <= sum;
            if (flush) begin
                q.delete();
            end else begin
                if (out_valid && out_ready) begin
                    chk("sb_nonempty", 32'(q.size() != 0), 32'd1);
                    if (q.size() != 0) begin
                        e = q.pop_front();
                        chk("sb_sum", 32'(sum), 32'(e[W+5:6]));
                        chk("sb_flags", 32'(dut_flags()), 32'(e[5:0] & FMASK));
                    end
                end
                if (in_valid && in_ready)
                    q.push_back(ref_model(a, b, cin, sub));
            end
        end else begin
            hold_p <= 1'b0;
        end
    end

    task automatic drive(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci, input logic sb);
        in_valid = 1'b1; a = x; b = y; cin = ci; sub = sb;
    endtask

    task automatic send_one(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                            input logic ci, input logic sb, input logic [W-1:0] es, input logic [5:0] ef);
        @(posedge clk); #1;
        drive(x, y, ci, sb);
        @(negedge clk);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk({tag, "_lat1"}, 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk({tag, "_lat2"}, 32'(out_valid), 32'd1);
        chk({tag, "_sum"}, 32'(sum), 32'(es));
        chk({tag, "_flags"}, 32'(dut_flags()), 32'(ef & FMASK));
    endtask

    initial begin
        logic [W-1:0] held;
        logic [W-1:0] pick [4];
        pick[0] = 16'h0000; pick[1] = 16'hFFFF; pick[2] = 16'h8000; pick[3] = 16'h7FFF;

        // reset state
        #2;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_flags", 32'(dut_flags()), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;

        // directed corners, flags packed {cf,of,zf,sf,af,pf}
        send_one("add_ovf",  16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 6'b010111);
        send_one("sub_brw",  16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 6'b100111);
        send_one("adc_zero", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 6'b101011);
        send_one("sub_ovf",  16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 6'b010011);

        // backpressure: two accepted, third stalls, then stream out without gaps
        @(posedge clk); #1;
        out_ready = 1'b0;
        drive(16'h1111, 16'h0101, 1'b0, 1'b0);
        @(negedge clk); chk("bp_acc1", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        drive(16'h2222, 16'h0202, 1'b1, 1'b0);
        @(negedge clk); chk("bp_acc2", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        drive(16'h3333, 16'h0303, 1'b0, 1'b1);
        @(negedge clk); chk("bp_full", 32'(in_ready), 32'd0);
        held = sum;
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_still_full", 32'(in_ready), 32'd0);
        chk("bp_hold", 32'(sum), 32'(held));
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_rel_ready", 32'(in_ready), 32'd1);
        chk("bp_stream0", 32'(out_valid), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk); chk("bp_stream1", 32'(out_valid), 32'd1);
        @(posedge clk); #1;
        @(negedge clk); chk("bp_stream2", 32'(out_valid), 32'd1);
        @(posedge clk); #1;
        @(negedge clk); chk("bp_drained", 32'(out_valid), 32'd0);

        // flush with two in flight; the flush-cycle input is discarded
        @(posedge clk); #1;
        out_ready = 1'b0;
        drive(16'h0F0F, 16'h00F1, 1'b0, 1'b0);
        @(posedge clk); #1;
        drive(16'hAAAA, 16'h5555, 1'b1, 1'b1);
        @(posedge clk); #1;
        drive(16'h1234, 16'h4321, 1'b0, 1'b0);
        flush = 1'b1; out_ready = 1'b1;
        @(negedge clk); chk("flush_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk); chk("flush_clear", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        @(negedge clk); chk("flush_no_stale", 32'(out_valid), 32'd0);

        // asynchronous reset pulse with two in flight
        @(posedge clk); #1;
        out_ready = 1'b0;
        drive(16'h4444, 16'h1111, 1'b0, 1'b0);
        @(posedge clk); #1;
        drive(16'h5555, 16'h2222, 1'b0, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk); chk("rst_pre_full", 32'(out_valid), 32'd1);
        #2;
        rst = 1'b1;
        q.delete();
        #1;
        chk("rst_async_valid", 32'(out_valid), 32'd0);
        chk("rst_async_sum", 32'(sum), 32'd0);
        chk("rst_async_ready", 32'(in_ready), 32'd1);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_no_stale", 32'(out_valid), 32'd0);
        end
        send_one("post_rst", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 6'b000011);

        // random traffic with backpressure and occasional flush
        for (int i = 0; i < 600; i++) begin
            @(posedge clk); #1;
            in_valid  = ($urandom_range(0, 3) != 0);
            a         = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 3)] : W'($urandom);
            b         = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 3)] : W'($urandom);
            cin       = 1'($urandom);
            sub       = 1'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 49) == 0);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("sb_drained", 32'(q.size()), 32'd0);
        chk("end_idle", 32'(out_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/add_pipe.md
ADD_PIPE -- requirements
Module: add_pipe

Interface
REQ-001 Parameter WIDTH, default 16: operand/result width; even, 8 <= WIDTH <= 64.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 in_valid  input  1  operand set present on a, b, cin, sub.
REQ-005 in_ready  output  1  block accepts operands this cycle.
REQ-006 a  input  WIDTH  first operand.
REQ-007 b  input  WIDTH  second operand.
REQ-008 cin  input  1  carry/borrow in (ADC/SBB); 0 for plain ADD/SUB.
REQ-009 sub  input  1  0 = a+b+cin, 1 = a-b-cin.
REQ-010 flush  input  1  synchronous discard of all in-flight results.
REQ-011 out_valid  output  1  result present on sum and flag outputs.
REQ-012 out_ready  input  1  consumer accepts result this cycle.
REQ-013 sum  output  WIDTH  result.
REQ-014 cf, of, zf, sf, af, pf  output  1 each  8086-style flags of the result.

Function
REQ-015 Transfer in: in_valid & in_ready at a clk edge; transfer out: out_valid & out_ready at a clk edge.
REQ-016 Two register stages; S1 computes low WIDTH/2 bits plus internal carry into bit WIDTH/2, registers high operand halves; S2 computes high half.
REQ-017 Latency exactly 2 cycles from input transfer to out_valid with no backpressure; throughput 1 result/cycle.
REQ-018 Subtract computed as a + ~b + ~cin over WIDTH bits; add as a + b + cin.
REQ-019 cf = carry out of MSB for add; inverted carry out (borrow) for sub.
REQ-020 of = carry into MSB XOR carry out of MSB; sf = sum[WIDTH-1]; zf = (sum == 0).
REQ-021 af = carry out of bit 3 for add, inverted for sub; pf = 1 when sum[7:0] has an even number of ones.
REQ-022 Stage advances when its successor is empty or being drained in the same cycle; in_ready = !S1.valid | S1 advances; S2 drained by out_ready.
REQ-023 With out_ready low, pipeline holds at most 2 results, then in_ready drops; held outputs remain stable while out_valid & !out_ready.
REQ-024 Simultaneous input and output transfer on a full pipeline: both occur, occupancy unchanged, no result lost or duplicated.
REQ-025 flush clears both stage valids at the next edge; in the flush cycle in_ready = 1 but the transfer is discarded; flush overrides out_ready.
REQ-026 Results emerge in input order; sum and flags unspecified when out_valid = 0.

Reset
REQ-027 rst high: S1/S2 valids cleared immediately; out_valid = 0, sum = 0, all flags = 0; in_ready = 1.
REQ-028 rst asserted mid-operation discards all in-flight results; first input transfer after rst deassert yields out_valid 2 cycles later.

Configuration
REQ-029 Macro ADD_PIPE_FLAGS_EN: defined -> of, af, pf, zf, sf computed per REQ-020/021 and pipelined with sum.
REQ-030 Not defined -> of, af, pf, zf, sf tied to 0, no flag logic or registers; sum and cf unaffected, ports remain present.

Verification (WIDTH=16, ADD_PIPE_FLAGS_EN defined)
REQ-031 Add 0x7FFF + 0x0001, cin=0 -> sum 0x8000, of=1, sf=1, cf=0, zf=0, af=1, pf=1, out_valid exactly 2 cycles after transfer.
REQ-032 Sub 0x0000 - 0x0001, cin=0 -> sum 0xFFFF, cf=1, sf=1, of=0, zf=0, af=1, pf=1.
REQ-033 Add 0xFFFF + 0x0000, cin=1 -> sum 0x0000, cf=1, zf=1, of=0, af=1, pf=1; Sub 0x8000 - 0x0001 -> 0x7FFF, of=1, cf=0.
REQ-034 out_ready=0, offer 3 back-to-back inputs -> 2 accepted, in_ready low on third; release out_ready -> 3 results in order, no gaps once streaming.
REQ-035 rst pulse (asynchronous, mid-cycle) with 2 results in flight -> out_valid falls without clk edge, no stale result after release; flush with 2 in flight -> out_valid 0 next cycle.
